// File: rtl/counter.sv
// rtl/counter.sv - enable-gated wrap-around up-counter with one-cycle overflow pulse
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // The pulse is raised on the same edge that carries count from all-ones to zero.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (enable) begin
      count_d    = count_q + ONE;
      overflow_d = &count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter (WIDTH=8 and WIDTH=1 instances)
module tb_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] count8;
  logic       ovf8;
  logic [0:0] count1;
  logic       ovf1;

  int total = 0;
  int bad   = 0;

  // Reference: number of increments since last reset; outputs follow by modular arithmetic.
  int unsigned n = 0;
  logic [7:0]  m_cnt8;
  logic        m_ovf8;

  counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .enable(enable), .count(count8), .overflow(ovf8)
  );

  counter #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .count(count1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic edge_step(input logic r, input logic e);
    @(negedge clk);
    rst    = r;
    enable = e;
    if (r) begin
      #1;
      check("async_rst_count8", 32'(count8), 32'd0);
      check("async_rst_ovf8", 32'(ovf8), 32'd0);
      check("async_rst_count1", 32'(count1), 32'd0);
    end
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) n = n + 1;
    m_cnt8 = 8'(n % 256);
    m_ovf8 = !r && e && (n % 256 == 0);
    check("w1_count", 32'(count1), 32'(n % 2));
    check("w1_ovf", 32'(ovf1), 32'(!r && e && (n % 2 == 0)));
  endtask

  task automatic expect8(input string name, input logic [7:0] c, input logic o);
    check({name, "_count"}, 32'(count8), 32'(c));
    check({name, "_ovf"}, 32'(ovf8), 32'(o));
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] c;
    logic       o;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst    = 1'b1;
    enable = 1'b0;

    vecs[0] = '{r: 1'b1, e: 1'b1, c: 8'd0, o: 1'b0};
    vecs[1] = '{r: 1'b1, e: 1'b1, c: 8'd0, o: 1'b0};
    vecs[2] = '{r: 1'b0, e: 1'b1, c: 8'd1, o: 1'b0};
    vecs[3] = '{r: 1'b0, e: 1'b1, c: 8'd2, o: 1'b0};
    vecs[4] = '{r: 1'b0, e: 1'b0, c: 8'd2, o: 1'b0};
    vecs[5] = '{r: 1'b0, e: 1'b0, c: 8'd2, o: 1'b0};
    vecs[6] = '{r: 1'b0, e: 1'b1, c: 8'd3, o: 1'b0};
    vecs[7] = '{r: 1'b1, e: 1'b0, c: 8'd0, o: 1'b0};
    vecs[8] = '{r: 1'b0, e: 1'b1, c: 8'd1, o: 1'b0};

    for (int i = 0; i < 9; i++) begin
      edge_step(vecs[i].r, vecs[i].e);
      expect8($sformatf("vec%0d", i), vecs[i].c, vecs[i].o);
    end

    // Continuous count through one wrap.
    edge_step(1'b1, 1'b0);
    expect8("cont_rst", 8'd0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      edge_step(1'b0, 1'b1);
      expect8("cont", 8'((i + 1) % 256), i == 255);
    end

    for (int i = 0; i < 10; i++) begin
      edge_step(1'b0, 1'b0);
      expect8("hold", 8'd4, 1'b0);
    end

    for (int i = 0; i < 50; i++) begin
      edge_step(1'b0, 1'b1);
      expect8("resume", 8'(5 + i), 1'b0);
    end

    // Mid-count reset at 100.
    edge_step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) edge_step(1'b0, 1'b1);
    expect8("at100", 8'd100, 1'b0);
    edge_step(1'b1, 1'b1);
    expect8("midrst", 8'd0, 1'b0);
    edge_step(1'b0, 1'b1);
    expect8("midrst_release", 8'd1, 1'b0);

    // Disable exactly at the wrap point, then re-enable for one edge.
    edge_step(1'b1, 1'b0);
    for (int i = 0; i < 255; i++) edge_step(1'b0, 1'b1);
    expect8("at255", 8'd255, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b0, 1'b0);
      expect8("wrap_hold", 8'd255, 1'b0);
    end
    edge_step(1'b0, 1'b1);
    expect8("wrap_reenable", 8'd0, 1'b1);
    edge_step(1'b0, 1'b1);
    expect8("after_wrap", 8'd1, 1'b0);

    // Reset while a wrap is pending: no pulse.
    for (int i = 0; i < 254; i++) edge_step(1'b0, 1'b1);
    expect8("at255b", 8'd255, 1'b0);
    edge_step(1'b1, 1'b1);
    expect8("pending_lost", 8'd0, 1'b0);
    edge_step(1'b0, 1'b1);
    expect8("pending_lost_next", 8'd1, 1'b0);

    // Randomized enable with occasional reset, against the arithmetic model.
    for (int i = 0; i < 1500; i++) begin
      logic r, e;
      r = ($urandom_range(99) == 0);
      e = ($urandom_range(3) != 0);
      edge_step(r, e);
      check("rand_count8", 32'(count8), 32'(m_cnt8));
      check("rand_ovf8", 32'(ovf8), 32'(m_ovf8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
